// File: rtl/datapath_pkg.sv
// Shared encodings for the BIP-I accumulator datapath: ACC input mux, ALU B mux, ALU op.
`timescale 1ns/1ps
package datapath_pkg;

  localparam logic [1:0] SEL_A_MEM  = 2'b00;
  localparam logic [1:0] SEL_A_IMM  = 2'b01;
  localparam logic [1:0] SEL_A_ALU  = 2'b10;
  localparam logic [1:0] SEL_A_HOLD = 2'b11;

  localparam logic SEL_B_MEM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/datapath_alu.sv
// Combinational two's-complement add/subtract; carry and borrow are dropped.
`timescale 1ns/1ps
module alu
  import datapath_pkg::*;
#(
  parameter int unsigned NB_DATA = 16
) (
  input  logic [NB_DATA-1:0] a,
  input  logic [NB_DATA-1:0] b,
  input  logic               op,
  output logic [NB_DATA-1:0] result
);

  always_comb begin
    result = a + b;
    if (op == OP_SUB) result = a - b;
  end

endmodule

// File: rtl/datapath.sv
// BIP-I accumulator datapath: operand sign-extension, A/B muxes, add/sub ALU and ACC register.
`timescale 1ns/1ps
module datapath
  import datapath_pkg::*;
#(
  parameter int unsigned NB_DATA    = 16,
  parameter int unsigned NB_OPERAND = 11,
  parameter int unsigned NB_ADDR    = 11,
  parameter int unsigned NB_OPCODE  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_SelA,
  input  logic                  i_SelB,
  input  logic                  i_WrAcc,
  input  logic                  i_op,
  input  logic [NB_OPERAND-1:0] i_operand,
  input  logic [NB_DATA-1:0]    i_data_memory,
  output logic [NB_ADDR-1:0]    o_addr,
  output logic [NB_DATA-1:0]    o_data_memory
);

  logic [NB_DATA-1:0] ext;
  logic [NB_DATA-1:0] b_mux;
  logic [NB_DATA-1:0] alu_res;
  logic [NB_DATA-1:0] a_mux;
  logic [NB_DATA-1:0] acc_d, acc_q;

  // Opcode width only keeps the port family uniform with the control unit.
  if (NB_OPCODE == 0) begin : g_no_opcode
  end

  if (NB_DATA > NB_OPERAND) begin : g_sext
    assign ext = {{(NB_DATA-NB_OPERAND){i_operand[NB_OPERAND-1]}}, i_operand};
  end else begin : g_trunc
    assign ext = i_operand[NB_DATA-1:0];
  end

  if (NB_ADDR > NB_OPERAND) begin : g_addr_zext
    assign o_addr = {{(NB_ADDR-NB_OPERAND){1'b0}}, i_operand};
  end else begin : g_addr_slice
    assign o_addr = i_operand[NB_ADDR-1:0];
  end

  always_comb begin
    b_mux = i_data_memory;
    if (i_SelB == SEL_B_IMM) b_mux = ext;
  end

  alu #(.NB_DATA(NB_DATA)) u_alu (
    .a      (acc_q),
    .b      (b_mux),
    .op     (i_op),
    .result (alu_res)
  );

  always_comb begin
    a_mux = acc_q;
    case (i_SelA)
      SEL_A_MEM:  a_mux = i_data_memory;
      SEL_A_IMM:  a_mux = ext;
      SEL_A_ALU:  a_mux = alu_res;
      SEL_A_HOLD: a_mux = acc_q;
      default:    a_mux = acc_q;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (i_WrAcc) acc_d = a_mux;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign o_data_memory = acc_q;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the BIP-I accumulator datapath with hand-computed expectations.
`timescale 1ns/1ps
module tb_datapath;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_SelA;
  logic        i_SelB;
  logic        i_WrAcc;
  logic        i_op;
  logic [10:0] i_operand;
  logic [15:0] i_data_memory;
  logic [10:0] o_addr;
  logic [15:0] o_data_memory;

  int n_chk  = 0;
  int n_fail = 0;

  always #2.5 i_clk = ~i_clk;

  datapath #(.NB_DATA(16), .NB_OPERAND(11), .NB_ADDR(11), .NB_OPCODE(5)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_SelA        (i_SelA),
    .i_SelB        (i_SelB),
    .i_WrAcc       (i_WrAcc),
    .i_op          (i_op),
    .i_operand     (i_operand),
    .i_data_memory (i_data_memory),
    .o_addr        (o_addr),
    .o_data_memory (o_data_memory)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are changed 1 ns after a rising edge, outputs sampled there too.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b0; i_WrAcc = 1'b1; i_SelA = 2'b01; i_SelB = 1'b0; i_op = 1'b0;
    i_operand = 11'd5; i_data_memory = 16'h0000;
    #1;
    chk("rst_initial", o_data_memory, 16'h0000);
    chk("rst_addr", {5'd0, o_addr}, 16'h0005);
    tick(); chk("rst_hold1", o_data_memory, 16'h0000);
    tick(); chk("rst_hold2", o_data_memory, 16'h0000);
    i_rst = 1'b1;
    #0.5 chk("rst_release_no_edge", o_data_memory, 16'h0000);
    tick(); chk("rst_release_ldi5", o_data_memory, 16'h0005);

    // Asynchronous clear mid-cycle, discarding the pending write
    i_operand = 11'd9;
    #1 i_rst = 1'b0;
    #0.5 chk("rst_async_clear", o_data_memory, 16'h0000);
    tick(); chk("rst_async_hold", o_data_memory, 16'h0000);
    i_rst = 1'b1;

    // LDI
    i_SelA = 2'b01; i_operand = 11'd1;
    tick(); chk("ldi_1", o_data_memory, 16'h0001);
    i_operand = 11'h7FF;
    tick(); chk("ldi_sext", o_data_memory, 16'hFFFF);

    // LD, then hold with WrAcc=0
    i_SelA = 2'b00; i_data_memory = 16'd2;
    tick(); chk("ld_2", o_data_memory, 16'h0002);
    i_WrAcc = 1'b0; i_data_memory = 16'd9;
    tick(); chk("wracc0_e1", o_data_memory, 16'h0002);
    tick(); chk("wracc0_e2", o_data_memory, 16'h0002);
    tick(); chk("wracc0_e3", o_data_memory, 16'h0002);

    // ADD / ADDI
    i_WrAcc = 1'b1; i_SelA = 2'b10; i_SelB = 1'b0; i_op = 1'b0; i_data_memory = 16'd4;
    tick(); chk("add_mem", o_data_memory, 16'h0006);
    i_SelB = 1'b1; i_operand = 11'd5;
    tick(); chk("addi_5", o_data_memory, 16'h000B);

    // SUB
    i_SelB = 1'b0; i_op = 1'b1; i_data_memory = 16'd8;
    tick(); chk("sub_mem", o_data_memory, 16'h0003);

    // Explicit hold select with WrAcc=1
    i_SelA = 2'b11;
    tick(); chk("sela_hold", o_data_memory, 16'h0003);

    // op must not affect LDI
    i_SelA = 2'b01; i_op = 1'b1; i_operand = 11'd2;
    tick(); chk("ldi_op_ignored", o_data_memory, 16'h0002);

    // SUBI wrap below zero, then ADDI wrap back
    i_operand = 11'd0; i_op = 1'b0;
    tick(); chk("ldi_0", o_data_memory, 16'h0000);
    i_SelA = 2'b10; i_SelB = 1'b1; i_op = 1'b1; i_operand = 11'd1;
    tick(); chk("subi_wrap", o_data_memory, 16'hFFFF);
    i_op = 1'b0;
    tick(); chk("addi_wrap", o_data_memory, 16'h0000);

    // Operation held over 3 enabled edges applied 3 times
    i_operand = 11'd3;
    tick(); chk("addi_rep1", o_data_memory, 16'h0003);
    tick(); chk("addi_rep2", o_data_memory, 16'h0006);
    tick(); chk("addi_rep3", o_data_memory, 16'h0009);

    // Negative immediate (-2) through the ALU
    i_operand = 11'h7FE;
    tick(); chk("addi_neg", o_data_memory, 16'h0007);

    // Memory-sourced add wrapping past 0xFFFF
    i_SelA = 2'b00; i_data_memory = 16'hFFFF;
    tick(); chk("ld_ffff", o_data_memory, 16'hFFFF);
    i_SelA = 2'b10; i_SelB = 1'b0; i_op = 1'b0; i_data_memory = 16'h0001;
    tick(); chk("add_wrap", o_data_memory, 16'h0000);

    // o_addr is combinational, independent of WrAcc and reset
    i_WrAcc = 1'b0; i_operand = 11'd3;
    #0.5 chk("addr_3", {5'd0, o_addr}, 16'h0003);
    i_operand = 11'h400;
    #0.5 chk("addr_400", {5'd0, o_addr}, 16'h0400);
    i_rst = 1'b0; i_operand = 11'h2AB;
    #0.5 chk("addr_in_reset", {5'd0, o_addr}, 16'h02AB);
    i_rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
